// File: rtl/path_click_sequencer.sv
// Mouse-click sequencer for the path-search engine: start/goal picking, request, wait, cue.
// Optional button debouncing is compiled in with `define CLICK_DEBOUNCE_EN.

module path_click_btn #(
   parameter int unsigned DEBOUNCE_CYC = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic click
);

   logic sync1;
   logic sync2;

`ifdef CLICK_DEBOUNCE_EN
   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic [DB_W-1:0] db_cnt;
   logic            filt;
   logic            filt_q;

   // The filtered level only follows the synchronised level after it has held steady.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         db_cnt <= '0;
         filt   <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         sync1  <= level;
         sync2  <= sync1;
         filt_q <= filt;
         if (sync2 == filt) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            filt   <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign click = filt & ~filt_q;
`else
   logic [31:0] cfg_unused;
   assign cfg_unused = DEBOUNCE_CYC;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= level;
         sync2 <= sync1;
      end
   end

   // sync1 is the registered level; sync2 doubles as its previous value.
   assign click = sync1 & ~sync2;
`endif

endmodule

module path_click_sequencer #(
   parameter int unsigned GRID_COLS    = 20,
   parameter int unsigned GRID_ROWS    = 15,
   parameter int unsigned CELL_PX_LOG2 = 5,
   parameter int unsigned NODE_W       = 9,
   parameter int unsigned TIMEOUT_CYC  = 50000000,
   parameter int unsigned DEBOUNCE_CYC = 250000
) (
   input  logic              iCLK_50,
   input  logic              iRST_n,
   input  logic              iLEFBUT,
   input  logic              iRIGBUT,
   input  logic [9:0]        iCUR_X,
   input  logic [9:0]        iCUR_Y,
   output logic              oREQ_VALID,
   input  logic              iREQ_READY,
   output logic [NODE_W-1:0] oSTART_NODE,
   output logic [NODE_W-1:0] oGOAL_NODE,
   input  logic              iSRCH_DONE,
   input  logic              iSRCH_FOUND,
   output logic              oABORT,
   output logic              oSOUND_TRIG,
   output logic              oFOUND,
   output logic              oERR,
   output logic [2:0]        oSTATE
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_HAVE_START = 3'd1,
      S_ISSUE      = 3'd2,
      S_WAIT       = 3'd3,
      S_RESULT     = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t state;
   state_t state_n;

   logic              left_raw;
   logic              right_raw;
   logic              left_click;
   logic              right_click;
   logic [9:0]        col;
   logic [9:0]        row;
   logic              on_grid;
   logic [NODE_W-1:0] cur_node;

   logic              done_q;
   logic              found_q;
   logic [CNT_W-1:0]  wait_cnt;
   logic              timeout_hit;

   logic              load_start;
   logic              load_goal;
   logic              load_found;
   logic              set_err;
   logic              clr_err;
   logic              abort_n;

   path_click_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_left_btn (
      .clk   (iCLK_50),
      .rst_n (iRST_n),
      .level (iLEFBUT),
      .click (left_raw)
   );

   path_click_btn #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_right_btn (
      .clk   (iCLK_50),
      .rst_n (iRST_n),
      .level (iRIGBUT),
      .click (right_raw)
   );

   assign col      = iCUR_X >> CELL_PX_LOG2;
   assign row      = iCUR_Y >> CELL_PX_LOG2;
   assign on_grid  = (col < 10'(GRID_COLS)) && (row < 10'(GRID_ROWS));
   assign cur_node = NODE_W'(32'(row) * GRID_COLS + 32'(col));

   // Off-grid clicks vanish entirely; a simultaneous right click swallows the left one.
   assign right_click = right_raw & on_grid;
   assign left_click  = left_raw & ~right_raw & on_grid;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_n    = state;
      load_start = 1'b0;
      load_goal  = 1'b0;
      load_found = 1'b0;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      abort_n    = 1'b0;
      case (state)
         S_IDLE: begin
            if (left_click) begin
               load_start = 1'b1;
               clr_err    = 1'b1;
               state_n    = S_HAVE_START;
            end
         end
         S_HAVE_START: begin
            if (right_click) begin
               state_n = S_IDLE;
            end else if (left_click && (cur_node != oSTART_NODE)) begin
               load_goal = 1'b1;
               state_n   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (iREQ_READY) begin
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (done_q) begin
               load_found = 1'b1;
               state_n    = S_RESULT;
            end else if (right_click) begin
               abort_n = 1'b1;
               state_n = S_IDLE;
            end else if (timeout_hit) begin
               abort_n = 1'b1;
               set_err = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_RESULT: begin
            state_n = S_DONE;
         end
         S_DONE: begin
            if (left_click) begin
               load_start = 1'b1;
               clr_err    = 1'b1;
               state_n    = S_HAVE_START;
            end else if (right_click) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // The completion pulse is registered so it lines up with the two-cycle click path.
   always_ff @(posedge iCLK_50) begin
      if (!iRST_n) begin
         state       <= S_IDLE;
         oSTART_NODE <= '0;
         oGOAL_NODE  <= '0;
         oFOUND      <= 1'b0;
         oERR        <= 1'b0;
         wait_cnt    <= '0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
      end else begin
         state   <= state_n;
         done_q  <= iSRCH_DONE;
         found_q <= iSRCH_FOUND;
         if (load_start) begin
            oSTART_NODE <= cur_node;
         end
         if (load_goal) begin
            oGOAL_NODE <= cur_node;
         end
         if (load_found) begin
            oFOUND <= found_q;
         end
         if (set_err) begin
            oERR <= 1'b1;
         end else if (clr_err) begin
            oERR <= 1'b0;
         end
         if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // Valid/ready: oREQ_VALID rises on entering ISSUE and stays high, with nodes frozen,
   // until the cycle in which iREQ_READY is sampled high; the request transfers on that edge.
   assign oREQ_VALID  = (state == S_ISSUE);
   assign oSOUND_TRIG = (state == S_RESULT);
   assign oABORT      = abort_n & iRST_n;
   assign oSTATE      = state;

endmodule

// File: tb/tb_path_click_sequencer.sv
// Bench for path_click_sequencer: directed scenarios plus random click/search sequences
// checked against a transaction-level model of the selection rules.

module tb_path_click_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lef = 1'b0;
   logic       rig = 1'b0;
   logic [9:0] cx = '0;
   logic [9:0] cy = '0;
   logic       ready = 1'b0;
   logic       done = 1'b0;
   logic       found_in = 1'b0;

   logic       req_valid;
   logic [8:0] start_node;
   logic [8:0] goal_node;
   logic       abort;
   logic       sound;
   logic       found;
   logic       err;
   logic [2:0] state;

   int checks = 0;
   int failures = 0;

   int m_state = 0;
   int m_start = 0;
   int m_goal = 0;
   int m_found = 0;
   int m_err = 0;

   always #10 clk = ~clk;

   path_click_sequencer #(.TIMEOUT_CYC(100)) dut (
      .iCLK_50     (clk),
      .iRST_n      (rst_n),
      .iLEFBUT     (lef),
      .iRIGBUT     (rig),
      .iCUR_X      (cx),
      .iCUR_Y      (cy),
      .oREQ_VALID  (req_valid),
      .iREQ_READY  (ready),
      .oSTART_NODE (start_node),
      .oGOAL_NODE  (goal_node),
      .iSRCH_DONE  (done),
      .iSRCH_FOUND (found_in),
      .oABORT      (abort),
      .oSOUND_TRIG (sound),
      .oFOUND      (found),
      .oERR        (err),
      .oSTATE      (state)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_state"}, 32'(state), 32'(m_state));
      chk({tag, "_valid"}, 32'(req_valid), 32'(m_state == 2));
      chk({tag, "_sound"}, 32'(sound), 32'(m_state == 4));
      chk({tag, "_abort"}, 32'(abort), 32'd0);
      chk({tag, "_start"}, 32'(start_node), 32'(m_start));
      chk({tag, "_goal"}, 32'(goal_node), 32'(m_goal));
      chk({tag, "_found"}, 32'(found), 32'(m_found));
      chk({tag, "_err"}, 32'(err), 32'(m_err));
   endtask

   task automatic model_reset();
      m_state = 0;
      m_start = 0;
      m_goal = 0;
      m_found = 0;
      m_err = 0;
   endtask

   // Press (and release) buttons with the cursor at (x,y); the model applies the selection rules.
   task automatic click(input bit l, input bit r, input int x, input int y, input string tag);
      int  node;
      bit  on;
      bit  lc;
      bit  exp_abort;
      int  prev;
      int  nxt;
      on = ((x / 32) < 20) && ((y / 32) < 15);
      node = (y / 32) * 20 + (x / 32);
      lc = l && !r;
      prev = m_state;
      nxt = m_state;
      exp_abort = 1'b0;
      if (on) begin
         case (m_state)
            0: if (lc) begin m_start = node; m_err = 0; nxt = 1; end
            1: begin
               if (r) nxt = 0;
               else if (lc && node != m_start) begin m_goal = node; nxt = 2; end
            end
            3: if (r) begin exp_abort = 1'b1; nxt = 0; end
            5: begin
               if (lc) begin m_start = node; m_err = 0; nxt = 1; end
               else if (r) nxt = 0;
            end
            default: ;
         endcase
      end
      cx = 10'(x);
      cy = 10'(y);
      lef = l;
      rig = r;
      tick();
      chk({tag, "_abort_pulse"}, 32'(abort), 32'(exp_abort));
      chk({tag, "_state_hold"}, 32'(state), 32'(prev));
      tick();
      m_state = nxt;
      check_outputs(tag);
      lef = 1'b0;
      rig = 1'b0;
      tick();
      tick();
   endtask

   task automatic issue(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid_held"}, 32'(req_valid), 32'd1);
         tick();
      end
      chk({tag, "_valid_ready_cycle"}, 32'(req_valid), 32'd1);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      m_state = 3;
      check_outputs(tag);
   endtask

   task automatic finish_search(input int delay, input bit f, input string tag);
      for (int i = 0; i < delay; i++) tick();
      done = 1'b1;
      found_in = f;
      tick();
      done = 1'b0;
      found_in = 1'b0;
      chk({tag, "_sound_early"}, 32'(sound), 32'd0);
      chk({tag, "_still_wait"}, 32'(state), 32'd3);
      tick();
      m_state = 4;
      m_found = f;
      check_outputs({tag, "_result"});
      tick();
      m_state = 5;
      check_outputs({tag, "_done"});
   endtask

   initial begin
      int x;
      int y;
      // reset
      rst_n = 1'b0;
      tick();
      tick();
      model_reset();
      check_outputs("reset");
      rst_n = 1'b1;
      tick();
      check_outputs("post_reset");

      // start/goal selection and request handshake
      click(1, 0, 40, 70, "start41");
      click(1, 0, 45, 90, "same_cell");
      click(1, 0, 300, 200, "goal129");
      click(0, 1, 100, 100, "right_in_issue");
      issue(10, "issue10");
      finish_search(3, 1'b1, "found1");
      click(0, 1, 20, 20, "done_right");

      // corner cell and timeout
      click(1, 0, 0, 0, "start0");
      click(1, 0, 639, 479, "goal299");
      issue(0, "issue0");
      for (int i = 1; i <= 99; i++) begin
         chk("timeout_no_abort", 32'(abort), 32'd0);
         tick();
      end
      chk("timeout_abort", 32'(abort), 32'd1);
      chk("timeout_state", 32'(state), 32'd3);
      tick();
      m_state = 0;
      m_err = 1;
      check_outputs("timeout_idle");

      // off-grid clicks and same-cycle left+right
      click(1, 0, 640, 0, "offgrid_x");
      click(1, 0, 0, 480, "offgrid_y");
      click(1, 0, 639, 479, "start299");
      click(1, 1, 100, 100, "both_buttons");

      // reset during ISSUE
      click(1, 0, 64, 64, "rst_start");
      click(1, 0, 96, 64, "rst_goal");
      rst_n = 1'b0;
      tick();
      model_reset();
      check_outputs("reset_in_issue");
      rst_n = 1'b1;
      tick();

      // user abort in WAIT
      click(1, 0, 10, 10, "ab_start");
      click(1, 0, 200, 300, "ab_goal");
      issue(2, "ab_issue");
      click(0, 1, 700, 10, "ab_offgrid_right");
      click(0, 1, 50, 50, "ab_right");
      click(1, 0, 10, 10, "f0_start");
      click(1, 0, 600, 10, "f0_goal");
      issue(1, "f0_issue");
      finish_search(0, 1'b0, "found0");
      click(1, 0, 330, 240, "done_left");

      // random sequences
      for (int step = 0; step < 60; step++) begin
         x = $urandom_range(0, 700);
         y = $urandom_range(0, 540);
         case (m_state)
            2: issue($urandom_range(0, 6), "rnd_issue");
            3: begin
               if ($urandom_range(0, 9) < 6) begin
                  finish_search($urandom_range(0, 8), 1'($urandom_range(0, 1)), "rnd_search");
               end else begin
                  click(0, 1, $urandom_range(0, 639), $urandom_range(0, 479), "rnd_abort");
               end
            end
            default: begin
               case ($urandom_range(0, 9))
                  0: click(1, 1, x, y, "rnd_both");
                  1, 2: click(0, 1, x, y, "rnd_right");
                  default: click(1, 0, x, y, "rnd_left");
               endcase
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
